// File: rtl/mux_dreg_pkg.sv
// mux_dreg_pkg: shared state encoding and parameter-range limits for the mux_dreg_bank block
package mux_dreg_pkg;
  typedef enum logic {RUN = 1'b0, HOLD = 1'b1} state_t;
  localparam int MIN_CHANNELS    = 1;
  localparam int MAX_CHANNELS    = 32;
  localparam int MIN_WIDTH       = 1;
  localparam int MAX_WIDTH       = 64;
  localparam int MIN_HOLD_CYCLES = 1;
  localparam int MAX_HOLD_CYCLES = 255;
endpackage

// File: rtl/mux_dreg_chan.sv
// mux_dreg_chan: one channel, 2:1 source mux into a register with load pulse and optional parity (MUX_DREG_PARITY_EN)
module mux_dreg_chan
  import mux_dreg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             sel,
  input  logic [WIDTH-1:0] d_a,
  input  logic [WIDTH-1:0] d_b,
  output logic [WIDTH-1:0] q,
`ifdef MUX_DREG_PARITY_EN
  output logic             q_par,
`endif
  output logic             upd
);
  logic [WIDTH-1:0] d_next;
  assign d_next = load ? (sel ? d_b : d_a) : q;
  // channel register recirculates unless loaded; upd marks the cycle a fresh load appears
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q   <= '0;
      upd <= 1'b0;
    end else begin
      q   <= d_next;
      upd <= load;
    end
  end
`ifdef MUX_DREG_PARITY_EN
  // parity tracks the value being written so it lines up with q
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_par <= 1'b0;
    else q_par <= ^d_next;
  end
`endif
endmodule

// File: rtl/mux_dreg_bank.sv
// mux_dreg_bank: bank of muxed load registers with a global HOLD freeze window; parity output via MUX_DREG_PARITY_EN
module mux_dreg_bank
  import mux_dreg_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int WIDTH       = 8,
  parameter int HOLD_CYCLES = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       en,
  input  logic [CHANNELS-1:0]       sel,
  input  logic [CHANNELS*WIDTH-1:0] d_a,
  input  logic [CHANNELS*WIDTH-1:0] d_b,
  input  logic                      hold_req,
  output logic [CHANNELS*WIDTH-1:0] q,
  output logic [CHANNELS-1:0]       upd,
`ifdef MUX_DREG_PARITY_EN
  output logic [CHANNELS-1:0]       q_par,
`endif
  output logic                      hold_busy
);
  localparam int CW = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(HOLD_CYCLES - 1);
  state_t state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [CHANNELS-1:0] load;
  // freeze-window FSM state and countdown register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end
  // RUN enters HOLD on a request; HOLD counts down and exits on the edge where cnt is zero
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    state_next = (state == RUN) ? (hold_req ? HOLD : RUN) : ((cnt == '0) ? RUN : HOLD);
    cnt_next   = (state == RUN) ? (hold_req ? CNT_LOAD : cnt) : ((cnt == '0) ? cnt : cnt - 1'b1);
  end
  assign hold_busy = (state == HOLD);
  assign load      = en & {CHANNELS{state == RUN}};
  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    mux_dreg_chan #(.WIDTH(WIDTH)) u_chan (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load[i]),
      .sel   (sel[i]),
      .d_a   (d_a[i*WIDTH +: WIDTH]),
      .d_b   (d_b[i*WIDTH +: WIDTH]),
      .q     (q[i*WIDTH +: WIDTH]),
`ifdef MUX_DREG_PARITY_EN
      .q_par (q_par[i]),
`endif
      .upd   (upd[i])
    );
  end
endmodule
